// File: rtl/cpu_pkg.sv
// Shared CPU constants: NOP encoding, fetch FSM state codes and default memory geometry.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t StRun  = 1'b0;
    localparam fetch_state_t StHalt = 1'b1;

    localparam int unsigned DEFAULT_MEM_WORDS = 32;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: fetch byte address out, combinational instruction word back.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] pc_addr;
    logic [31:0]       instr;

    modport master (output pc_addr, input instr);
    modport slave  (input pc_addr, output instr);
endinterface

// File: rtl/fetch_pc_sel.sv
// Next-PC selection: jump > branch > stall > PC+4, with word-aligned redirect targets.
module fetch_pc_sel #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              redirect_o,
    output logic              misaligned_o
);

    logic [ADDR_W-1:0] raw_target;

    // Branch target is ignored entirely when a jump is present, alignment check included.
    assign raw_target   = jump_i ? jump_target_i : branch_target_i;
    assign redirect_o   = jump_i | branch_i;
    assign misaligned_o = redirect_o & (|raw_target[1:0]);

    always_comb begin
        next_pc_o = pc_i + ADDR_W'(4);
        if (redirect_o) begin
            next_pc_o = {raw_target[ADDR_W-1:2], 2'b00};
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, drives instruction memory and fills the IF/ID register.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      branch_i,
    input  logic [ADDR_W-1:0]         branch_target_i,
    input  logic                      jump_i,
    input  logic [ADDR_W-1:0]         jump_target_i,
    instr_fetch_unit_if.master        imem_io,
    output logic [31:0]               instr_o,
    output logic [ADDR_W-1:0]         pc_plus4_o,
    output logic                      valid_o,
    output logic                      halted_o,
    output logic                      align_err_o,
    output logic [31:0]               fetch_cnt_o
);

    // One extra bit so the limit itself is representable even when it equals 2^ADDR_W.
    localparam logic [ADDR_W:0] PcLimit = (ADDR_W+1)'(MEM_WORDS) << 2;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, sel_pc, pc_plus4;
    logic [31:0]       instr_q, instr_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d, align_q, align_d;
    logic              redirect, misaligned, pc_oor, target_ok;

    fetch_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_sel (
        .pc_i            (pc_q),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .next_pc_o       (sel_pc),
        .redirect_o      (redirect),
        .misaligned_o    (misaligned)
    );

    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign pc_oor    = {1'b0, pc_q} >= PcLimit;
    assign target_ok = {1'b0, sel_pc} < PcLimit;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        align_d = align_q | misaligned;

        if (state_q == StHalt) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pc4_d   = '0;
            if (redirect && target_ok) begin
                state_d = StRun;
                pc_d    = sel_pc;
            end
        end else begin
            if (redirect || !pc_oor) begin
                pc_d = sel_pc;
            end else begin
                state_d = StHalt;
            end

            if (flush_i || redirect) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                pc4_d   = '0;
            end else if (stall_i) begin
                instr_d = instr_q;
            end else if (pc_oor) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                pc4_d   = '0;
            end else begin
                instr_d = imem_io.instr;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            align_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            align_q <= align_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_io.pc_addr = pc_q;
    assign instr_o         = instr_q;
    assign pc_plus4_o      = pc4_q;
    assign valid_o         = valid_q;
    assign halted_o        = (state_q == StHalt);
    assign align_err_o     = align_q;
    assign fetch_cnt_o     = cnt_q;

endmodule
